// File: rtl/dis_pal_src_arbiter.sv
// -----------------------------------------------------------------------------
// dis_pal_src_arbiter
//   Frame-granular arbiter that shares the PAL display pipeline between two
//   Avalon-ST video sources. A granted source keeps the pipeline for a complete
//   control+video packet sequence. The lock is released only after the eop of a
//   video packet (type 4'h0). A watchdog aborts a source that stalls for too
//   long.
//
// Parameters
//   DATA_WIDTH : width of all data buses (must be >= 4)
//   ARB_MODE   : 0 = preference taken from sel, 1 = round robin per video packet
//   TIMEOUT    : consecutive valid-low lock cycles before abort (>= 1)
//
// Ports
//   vst_clk, vst_rst_n          : clock, asynchronous active-low reset
//   a_* / b_*                   : source A / B Avalon-ST sink side
//   dout_*                      : Avalon-ST source towards dis_pal_decode
//   sel                         : preferred source in ARB_MODE 0 (0 = A, 1 = B)
//   active_src                  : source currently or last granted
//   timeout_flag                : sticky abort indicator, cleared on next grant
// -----------------------------------------------------------------------------
module dis_pal_src_arbiter #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ARB_MODE   = 0,
  parameter logic [23:0] TIMEOUT    = 24'd2_000_000
) (
  input  logic                  vst_clk,
  input  logic                  vst_rst_n,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_startofpacket,
  input  logic                  a_endofpacket,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_startofpacket,
  input  logic                  b_endofpacket,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  sel,
  output logic                  active_src,
  output logic                  timeout_flag
);

  localparam logic RR = (ARB_MODE == 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_active_src, w_active_nxt;
  logic                  r_timeout_flag, w_flag_nxt;
  logic                  r_rr_ptr, w_ptr_nxt;
  logic [3:0]            r_pkt_type, w_pkt_type_nxt;
  logic [23:0]           r_wd_cnt, w_wd_cnt_nxt;

  logic                  w_a_req, w_b_req, w_pref;
  logic [DATA_WIDTH-1:0] w_x_data;
  logic                  w_x_valid, w_x_sop, w_x_eop;
  logic                  w_beat;
  logic [3:0]            w_type;

  assign w_a_req = a_valid & a_startofpacket;
  assign w_b_req = b_valid & b_startofpacket;
  assign w_pref  = RR ? r_rr_ptr : sel;

  // Beat of the locked source (only meaningful in a LOCK state)
  always_comb begin
    if (r_state == ST_LOCK_B) begin
      w_x_data  = b_data;
      w_x_valid = b_valid;
      w_x_sop   = b_startofpacket;
      w_x_eop   = b_endofpacket;
    end else begin
      w_x_data  = a_data;
      w_x_valid = a_valid;
      w_x_sop   = a_startofpacket;
      w_x_eop   = a_endofpacket;
    end
  end

  assign w_beat = w_x_valid & dout_ready;
  // A single-beat packet carries its own type on the eop beat
  assign w_type = w_x_sop ? w_x_data[3:0] : r_pkt_type;

  always_comb begin
    w_state_nxt        = r_state;
    w_active_nxt       = r_active_src;
    w_flag_nxt         = r_timeout_flag;
    w_ptr_nxt          = r_rr_ptr;
    w_pkt_type_nxt     = r_pkt_type;
    w_wd_cnt_nxt       = r_wd_cnt;
    a_ready            = 1'b0;
    b_ready            = 1'b0;
    dout_data          = '0;
    dout_valid         = 1'b0;
    dout_startofpacket = 1'b0;
    dout_endofpacket   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Stray mid-packet beats are swallowed; requesters wait with ready low
        a_ready = vst_rst_n & a_valid & ~a_startofpacket;
        b_ready = vst_rst_n & b_valid & ~b_startofpacket;
        if (w_a_req && (!w_pref || !w_b_req)) begin
          w_state_nxt  = ST_LOCK_A;
          w_active_nxt = 1'b0;
          w_flag_nxt   = 1'b0;
          w_wd_cnt_nxt = '0;
        end else if (w_b_req) begin
          w_state_nxt  = ST_LOCK_B;
          w_active_nxt = 1'b1;
          w_flag_nxt   = 1'b0;
          w_wd_cnt_nxt = '0;
        end
      end

      ST_LOCK_A, ST_LOCK_B: begin
        dout_data          = w_x_data;
        dout_valid         = w_x_valid;
        dout_startofpacket = w_x_sop;
        dout_endofpacket   = w_x_eop;
        if (r_state == ST_LOCK_A) a_ready = dout_ready;
        else                      b_ready = dout_ready;

        if (w_beat) begin
          // An accepted beat takes priority over a simultaneous watchdog expiry
          w_wd_cnt_nxt = '0;
          if (w_x_sop) w_pkt_type_nxt = w_x_data[3:0];
          if (w_x_eop && (w_type == 4'h0)) begin
            w_state_nxt = ST_IDLE;
            if (RR) w_ptr_nxt = ~r_rr_ptr;
          end
        end else if (!w_x_valid) begin
          // Backpressure (valid high, dout_ready low) holds the count
          if (r_wd_cnt == TIMEOUT - 24'd1) begin
            w_state_nxt  = ST_IDLE;
            w_flag_nxt   = 1'b1;
            w_wd_cnt_nxt = '0;
            if (RR) w_ptr_nxt = ~r_rr_ptr;
          end else begin
            w_wd_cnt_nxt = r_wd_cnt + 24'd1;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      r_state        <= ST_IDLE;
      r_active_src   <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_rr_ptr       <= 1'b0;
      r_pkt_type     <= '0;
      r_wd_cnt       <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_active_src   <= w_active_nxt;
      r_timeout_flag <= w_flag_nxt;
      r_rr_ptr       <= w_ptr_nxt;
      r_pkt_type     <= w_pkt_type_nxt;
      r_wd_cnt       <= w_wd_cnt_nxt;
    end
  end

  assign active_src   = r_active_src;
  assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_dis_pal_src_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dis_pal_src_arbiter
//   Two arbiters side by side: dut0 (fixed preference, TIMEOUT 100) and dut1
//   (round robin, TIMEOUT 20). Sources are beat queues; every cycle all outputs
//   of both instances are compared with a frame-level reference model.
//   Index convention: source i = 2*dut + (0 for A, 1 for B).
// -----------------------------------------------------------------------------
module tb_dis_pal_src_arbiter;
  localparam int DW = 10;
  localparam int T0 = 100;
  localparam int T1 = 20;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct packed {
    logic          ar;
    logic          br;
    logic          dv;
    logic          dsop;
    logic          deop;
    logic [DW-1:0] dd;
    logic          act;
    logic          flag;
  } obs_t;

  typedef struct {
    bit av, as, bv, bs, sl;
    bit ar0, br0;
    bit ar1, br1, act1, dv1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          vld [4];
  logic          sp  [4];
  logic          ep  [4];
  logic [DW-1:0] dat [4];
  logic          rdy [4];
  logic          drdy [2];
  logic          sel  [2];
  logic          ov   [2];
  logic          osop [2];
  logic          oeop [2];
  logic [DW-1:0] odat [2];
  logic          oact [2];
  logic          oflag[2];

  dis_pal_src_arbiter #(.DATA_WIDTH(DW), .ARB_MODE(0), .TIMEOUT(24'd100)) u_dut0 (
    .vst_clk(clk), .vst_rst_n(rst_n),
    .a_data(dat[0]), .a_valid(vld[0]), .a_ready(rdy[0]),
    .a_startofpacket(sp[0]), .a_endofpacket(ep[0]),
    .b_data(dat[1]), .b_valid(vld[1]), .b_ready(rdy[1]),
    .b_startofpacket(sp[1]), .b_endofpacket(ep[1]),
    .dout_data(odat[0]), .dout_valid(ov[0]), .dout_ready(drdy[0]),
    .dout_startofpacket(osop[0]), .dout_endofpacket(oeop[0]),
    .sel(sel[0]), .active_src(oact[0]), .timeout_flag(oflag[0])
  );

  dis_pal_src_arbiter #(.DATA_WIDTH(DW), .ARB_MODE(1), .TIMEOUT(24'd20)) u_dut1 (
    .vst_clk(clk), .vst_rst_n(rst_n),
    .a_data(dat[2]), .a_valid(vld[2]), .a_ready(rdy[2]),
    .a_startofpacket(sp[2]), .a_endofpacket(ep[2]),
    .b_data(dat[3]), .b_valid(vld[3]), .b_ready(rdy[3]),
    .b_startofpacket(sp[3]), .b_endofpacket(ep[3]),
    .dout_data(odat[1]), .dout_valid(ov[1]), .dout_ready(drdy[1]),
    .dout_startofpacket(osop[1]), .dout_endofpacket(oeop[1]),
    .sel(sel[1]), .active_src(oact[1]), .timeout_flag(oflag[1])
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  beat_t q   [4][$];
  int    gap [4];
  bit    use_q, rand_en, rec_gl;
  int    ndout [2];
  bit    gl [$];

  // Reference model: owner 0 = nobody, 1 = A, 2 = B
  int m_own [2];
  bit m_ptr [2];
  bit m_flag[2];
  bit m_act [2];
  int m_ptype[2];
  int m_stall[2];
  int m_mode[2] = '{0, 1};
  int m_to  [2] = '{T0, T1};

  function automatic obs_t model_out(int d);
    obs_t o;
    int   x;
    o = '0;
    if (rst_n !== 1'b1) return o;
    o.act  = m_act[d];
    o.flag = m_flag[d];
    if (m_own[d] == 0) begin
      o.ar = vld[2*d]   && !sp[2*d];
      o.br = vld[2*d+1] && !sp[2*d+1];
    end else begin
      x      = 2*d + m_own[d] - 1;
      o.dv   = vld[x];
      o.dsop = sp[x];
      o.deop = ep[x];
      o.dd   = dat[x];
      if (m_own[d] == 1) o.ar = drdy[d];
      else               o.br = drdy[d];
    end
    return o;
  endfunction

  function automatic obs_t dut_obs(int d);
    obs_t o;
    o.ar = rdy[2*d];  o.br = rdy[2*d+1];
    o.dv = ov[d];     o.dsop = osop[d];  o.deop = oeop[d];
    o.dd = odat[d];   o.act = oact[d];   o.flag = oflag[d];
    return o;
  endfunction

  task automatic model_step(int d);
    int x, t;
    bit ra, rb, pref;
    if (rst_n !== 1'b1) begin
      m_own[d] = 0; m_ptr[d] = 0; m_flag[d] = 0; m_act[d] = 0;
      m_ptype[d] = 0; m_stall[d] = 0;
      return;
    end
    if (m_own[d] == 0) begin
      ra   = vld[2*d] && sp[2*d];
      rb   = vld[2*d+1] && sp[2*d+1];
      pref = (m_mode[d] == 1) ? m_ptr[d] : sel[d];
      x    = 0;
      if (pref == 0) x = ra ? 1 : (rb ? 2 : 0);
      else           x = rb ? 2 : (ra ? 1 : 0);
      if (x != 0) begin
        m_own[d] = x; m_act[d] = (x == 2); m_flag[d] = 0; m_stall[d] = 0;
      end
    end else begin
      x = 2*d + m_own[d] - 1;
      if (vld[x] && drdy[d]) begin
        if (sp[x]) m_ptype[d] = int'(dat[x][3:0]);
        t = m_ptype[d];
        m_stall[d] = 0;
        if (ep[x] && t == 0) begin
          m_own[d] = 0;
          if (m_mode[d] == 1) m_ptr[d] = !m_ptr[d];
        end
      end else if (!vld[x]) begin
        m_stall[d]++;
        if (m_stall[d] >= m_to[d]) begin
          m_own[d] = 0; m_flag[d] = 1;
          if (m_mode[d] == 1) m_ptr[d] = !m_ptr[d];
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic drive();
    if (!use_q) return;
    for (int i = 0; i < 4; i++) begin
      if (rand_en && gap[i] == 0) begin
        if ($urandom_range(0, 24) == 0)       gap[i] = $urandom_range(1, 30);
        else if ($urandom_range(0, 299) == 0) gap[i] = $urandom_range(95, 130);
      end
      if (gap[i] > 0) begin
        gap[i]--;
        vld[i] = 1'b0;
        sp[i]  = 1'($urandom_range(0, 1));
        ep[i]  = 1'($urandom_range(0, 1));
        dat[i] = DW'($urandom_range(0, 1023));
      end else if (q[i].size() > 0) begin
        vld[i] = 1'b1;
        dat[i] = q[i][0].data;
        sp[i]  = q[i][0].sop;
        ep[i]  = q[i][0].eop;
      end else begin
        vld[i] = 1'b0; sp[i] = 1'b0; ep[i] = 1'b0;
      end
    end
    if (rand_en)
      for (int d = 0; d < 2; d++) drdy[d] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic tick();
    obs_t e, a;
    bit   pop [4];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e = model_out(d);
      a = dut_obs(d);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle%0d dut%0d {ar,br,v,sop,eop,data,act,flag} got %b want %b",
                 cyc, d, a, e);
      end
      if (ov[d] === 1'b1 && drdy[d]) ndout[d]++;
    end
    if (rec_gl && ov[1] === 1'b1 && drdy[1] && osop[1] === 1'b1 && odat[1][3:0] == 4'hF)
      gl.push_back(oact[1]);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      e = model_out(d);
      pop[2*d]   = use_q && vld[2*d]   && e.ar;
      pop[2*d+1] = use_q && vld[2*d+1] && e.br;
      model_step(d);
    end
    for (int i = 0; i < 4; i++) if (pop[i]) void'(q[i].pop_front());
    #1;
    drive();
    cyc++;
  endtask

  task automatic push_pkt(input int i, input int typ, input int len, input bit with_eop);
    beat_t b;
    logic [DW-1:0] dv;
    for (int k = 0; k < len; k++) begin
      dv = DW'($urandom_range(0, 1023));
      if (k == 0) dv[3:0] = typ[3:0];
      b.data = dv;
      b.sop  = (k == 0);
      b.eop  = with_eop && (k == len - 1);
      q[i].push_back(b);
    end
  endtask

  task automatic push_junk(input int i, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = DW'($urandom_range(0, 1023));
      b.sop  = 1'b0;
      b.eop  = 1'($urandom_range(0, 1));
      q[i].push_back(b);
    end
  endtask

  task automatic push_frame(input int i);
    if ($urandom_range(0, 7) == 0) push_junk(i, $urandom_range(1, 3));
    if ($urandom_range(0, 5) == 0) push_pkt(i, 3, $urandom_range(1, 4), 1'b1);
    push_pkt(i, 15, $urandom_range(1, 4), 1'b1);
    push_pkt(i, 0, $urandom_range(1, 8), 1'b1);
  endtask

  task automatic do_reset();
    use_q = 0; rand_en = 0; rec_gl = 0;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 0; sp[i] = 0; ep[i] = 0; dat[i] = '0; gap[i] = 0;
      q[i].delete();
    end
    for (int d = 0; d < 2; d++) begin
      drdy[d] = 1; sel[d] = 0; ndout[d] = 0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t vt [10];
  int   n;

  initial begin
    vt[0] = '{1,0,0,0,0, 1,0, 1,0,0,0};
    vt[1] = '{0,0,1,0,0, 0,1, 0,1,0,0};
    vt[2] = '{1,1,0,0,0, 0,0, 1,0,0,1};
    vt[3] = '{0,0,1,1,0, 0,0, 0,1,1,1};
    vt[4] = '{1,1,1,1,1, 0,0, 0,1,1,1};
    vt[5] = '{1,1,1,1,0, 0,0, 1,0,0,1};
    vt[6] = '{1,1,1,0,1, 0,1, 1,0,0,1};
    vt[7] = '{1,0,1,1,0, 1,0, 0,1,1,1};
    vt[8] = '{0,0,0,0,1, 0,0, 0,0,0,0};
    vt[9] = '{0,1,0,1,0, 0,0, 0,0,0,0};

    // Reset state with flush-looking inputs present
    use_q = 0; rand_en = 0; rec_gl = 0; rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1; sp[i] = 0; ep[i] = 0; dat[i] = '0; gap[i] = 0;
    end
    for (int d = 0; d < 2; d++) begin drdy[d] = 1; sel[d] = 0; ndout[d] = 0; end
    for (int d = 0; d < 2; d++) model_step(d);
    tick();
    chk("reset_a_ready", rdy[0], 0);
    chk("reset_b_ready", rdy[1], 0);
    chk("reset_active", oact[1], 0);

    // Single IDLE-cycle vectors on dut0
    for (int v = 0; v < 10; v++) begin
      do_reset();
      vld[0] = vt[v].av; sp[0] = vt[v].as; dat[0] = 10'h2A0;
      vld[1] = vt[v].bv; sp[1] = vt[v].bs; dat[1] = 10'h150;
      sel[0] = vt[v].sl;
      #2;
      chk($sformatf("vec%0d_a_ready_idle", v), rdy[0], vt[v].ar0);
      chk($sformatf("vec%0d_b_ready_idle", v), rdy[1], vt[v].br0);
      chk($sformatf("vec%0d_dout_valid_idle", v), ov[0], 0);
      tick();
      chk($sformatf("vec%0d_a_ready_next", v), rdy[0], vt[v].ar1);
      chk($sformatf("vec%0d_b_ready_next", v), rdy[1], vt[v].br1);
      chk($sformatf("vec%0d_active_next", v), oact[0], vt[v].act1);
      chk($sformatf("vec%0d_dout_valid_next", v), ov[0], vt[v].dv1);
    end

    // Full frame from A: ctrl 10 beats then 720x4 video beats
    do_reset();
    use_q = 1;
    push_pkt(0, 15, 10, 1'b1);
    push_pkt(0, 0, 2880, 1'b1);
    drive();
    n = 0;
    while (q[0].size() > 0 && n < 4000) begin tick(); n++; end
    chk("frame_dout_beats", ndout[0], 2890);
    chk("frame_active", oact[0], 0);
    drdy[0] = 0;
    push_junk(0, 1);
    drive();
    #1;
    chk("frame_idle_after_eop", rdy[0], 1);
    tick();

    // Simultaneous requests, sel = B
    do_reset();
    use_q = 1; sel[0] = 1;
    push_pkt(0, 15, 3, 1'b1); push_pkt(0, 0, 5, 1'b1);
    push_pkt(1, 15, 3, 1'b1); push_pkt(1, 0, 5, 1'b1);
    drive();
    tick();
    chk("both_req_active_b", oact[0], 1);
    n = 0;
    while (q[1].size() > 0 && n < 100) begin
      if (rdy[0] !== 1'b0) chk("both_req_a_held", rdy[0], 0);
      tick(); n++;
    end
    tick();
    chk("both_req_then_a", oact[0], 0);
    n = 0;
    while (q[0].size() > 0 && n < 100) begin tick(); n++; end
    chk("both_req_beats", ndout[0], 16);

    // B sends 5 beats without sop while idle
    do_reset();
    use_q = 1;
    push_junk(1, 5);
    drive();
    for (int k = 0; k < 5; k++) begin
      #2;
      chk($sformatf("flush_b_ready%0d", k), rdy[1], 1);
      chk($sformatf("flush_dout_valid%0d", k), ov[0], 0);
      tick();
    end

    // Watchdog: A stops after 50 video beats, B waiting
    do_reset();
    use_q = 1;
    push_pkt(0, 0, 50, 1'b0);
    push_pkt(1, 0, 4, 1'b1);
    drive();
    tick();
    for (int k = 0; k < 50; k++) tick();
    chk("wd_beats_before_stall", ndout[0], 50);
    n = 0;
    while (oflag[0] !== 1'b1 && n < 300) begin tick(); n++; end
    chk("wd_stall_cycles", n, T0);
    chk("wd_active_still_a", oact[0], 0);
    tick();
    chk("wd_flag_cleared_on_grant", oflag[0], 0);
    chk("wd_grant_b", oact[0], 1);
    for (int k = 0; k < 6; k++) tick();

    // Backpressure stall of 500 cycles does not abort
    do_reset();
    use_q = 1;
    push_pkt(0, 15, 4, 1'b1);
    push_pkt(0, 0, 20, 1'b1);
    drive();
    for (int k = 0; k < 10; k++) tick();
    drdy[0] = 0;
    for (int k = 0; k < 500; k++) tick();
    chk("bp_no_abort", oflag[0], 0);
    drdy[0] = 1;
    n = 0;
    while (q[0].size() > 0 && n < 100) begin tick(); n++; end
    chk("bp_packet_intact", ndout[0], 24);
    chk("bp_no_abort_end", oflag[0], 0);

    // Round robin on dut1 with both sources streaming back to back
    do_reset();
    use_q = 1; rec_gl = 1;
    for (int f = 0; f < 4; f++) begin
      push_pkt(2, 15, 2, 1'b1); push_pkt(2, 0, 3, 1'b1);
      push_pkt(3, 15, 2, 1'b1); push_pkt(3, 0, 3, 1'b1);
    end
    drive();
    n = 0;
    while ((q[2].size() > 0 || q[3].size() > 0) && n < 200) begin tick(); n++; end
    rec_gl = 0;
    chk("rr_frame_count", gl.size(), 8);
    for (int k = 0; k < gl.size(); k++)
      chk($sformatf("rr_frame%0d_src", k), int'(gl[k]), k % 2);

    // Randomized traffic on both instances
    do_reset();
    use_q = 1; rand_en = 1;
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < 4; i++) if (q[i].size() < 4) push_frame(i);
      if ($urandom_range(0, 99) == 0) sel[0] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) sel[1] = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
